l2_arbiter: RTL and testbench

- Shares the single unified L2 cache port between the L1 I-cache (read-only) and the L1 D-cache (read/write) in the pipelined LC-3b.
- Sits between both L1 miss/writeback interfaces (128-bit lines) and the L2 controller.
- Registers one grant per transaction and latches the winning request so the L2 side is stable until it responds.
- Round-robin on conflict by default; a parameter selects fixed D-cache priority.

---
 rtl/l2_arbiter.sv | 103 ++++++++++
 tb/tb_l2_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// Two-way arbiter sharing the unified L2 port between the L1 I-cache and D-cache.
// One grant per transaction; the winning request is latched so L2 sees a stable request.
module l2_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int LINE_WIDTH   = 128,
    parameter bit FIXED_D_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [LINE_WIDTH-1:0] i_mem_rdata,
    output logic                  i_mem_resp,
    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [LINE_WIDTH-1:0] d_mem_wdata,
    output logic [LINE_WIDTH-1:0] d_mem_rdata,
    output logic                  d_mem_resp,
    output logic                  l2_mem_read,
    output logic                  l2_mem_write,
    output logic [ADDR_WIDTH-1:0] l2_mem_address,
    output logic [LINE_WIDTH-1:0] l2_mem_wdata,
    input  logic [LINE_WIDTH-1:0] l2_mem_rdata,
    input  logic                  l2_mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   i_req;
    logic   d_req;
    logic   grant_i;
    logic   grant_d;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

    // D wins a conflict under fixed priority, or when I held the previous grant.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_req && (!i_req || FIXED_D_PRIO || !last_grant)) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end
    end

    // The l2_mem_* registers are the latched copy of the winning request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b0;
            l2_mem_read    <= 1'b0;
            l2_mem_write   <= 1'b0;
            l2_mem_address <= '0;
            l2_mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state          <= SERVE_D;
                        last_grant     <= 1'b1;
                        l2_mem_read    <= ~d_mem_write;
                        l2_mem_write   <= d_mem_write;
                        l2_mem_address <= d_mem_address;
                        l2_mem_wdata   <= d_mem_wdata;
                    end else if (grant_i) begin
                        state          <= SERVE_I;
                        last_grant     <= 1'b0;
                        l2_mem_read    <= 1'b1;
                        l2_mem_write   <= 1'b0;
                        l2_mem_address <= i_mem_address;
                        l2_mem_wdata   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (l2_mem_resp) begin
                        state        <= IDLE;
                        l2_mem_read  <= 1'b0;
                        l2_mem_write <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A response in IDLE belongs to nobody and is dropped.
    assign i_mem_resp  = (state == SERVE_I) && l2_mem_resp;
    assign d_mem_resp  = (state == SERVE_D) && l2_mem_resp;
    assign i_mem_rdata = l2_mem_rdata;
    assign d_mem_rdata = l2_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model, covering both arbitration modes.
module tb_l2_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_rd = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          d_rd = 1'b0;
    logic          d_wr = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] l2_rdata = '0;
    logic          l2_resp = 1'b0;
    logic          sel = 1'b0;

    logic [LW-1:0] i_rdata0, i_rdata1, d_rdata0, d_rdata1, l2_wdata0, l2_wdata1;
    logic          i_resp0, i_resp1, d_resp0, d_resp1;
    logic          l2_rd0, l2_rd1, l2_wr0, l2_wr1;
    logic [AW-1:0] l2_addr0, l2_addr1;
    logic          l2_resp0, l2_resp1;

    logic [LW-1:0] o_i_rdata, o_d_rdata, o_l2_wdata;
    logic          o_i_resp, o_d_resp, o_l2_rd, o_l2_wr;
    logic [AW-1:0] o_l2_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign l2_resp0   = sel ? 1'b0 : l2_resp;
    assign l2_resp1   = sel ? l2_resp : 1'b0;
    assign o_i_rdata  = sel ? i_rdata1 : i_rdata0;
    assign o_d_rdata  = sel ? d_rdata1 : d_rdata0;
    assign o_i_resp   = sel ? i_resp1 : i_resp0;
    assign o_d_resp   = sel ? d_resp1 : d_resp0;
    assign o_l2_rd    = sel ? l2_rd1 : l2_rd0;
    assign o_l2_wr    = sel ? l2_wr1 : l2_wr0;
    assign o_l2_addr  = sel ? l2_addr1 : l2_addr0;
    assign o_l2_wdata = sel ? l2_wdata1 : l2_wdata0;

    l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_D_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .i_mem_read(i_rd), .i_mem_address(i_addr), .i_mem_rdata(i_rdata0), .i_mem_resp(i_resp0),
        .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_address(d_addr), .d_mem_wdata(d_wdata),
        .d_mem_rdata(d_rdata0), .d_mem_resp(d_resp0),
        .l2_mem_read(l2_rd0), .l2_mem_write(l2_wr0), .l2_mem_address(l2_addr0),
        .l2_mem_wdata(l2_wdata0), .l2_mem_rdata(l2_rdata), .l2_mem_resp(l2_resp0)
    );

    l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .FIXED_D_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset),
        .i_mem_read(i_rd), .i_mem_address(i_addr), .i_mem_rdata(i_rdata1), .i_mem_resp(i_resp1),
        .d_mem_read(d_rd), .d_mem_write(d_wr), .d_mem_address(d_addr), .d_mem_wdata(d_wdata),
        .d_mem_rdata(d_rdata1), .d_mem_resp(d_resp1),
        .l2_mem_read(l2_rd1), .l2_mem_write(l2_wr1), .l2_mem_address(l2_addr1),
        .l2_mem_wdata(l2_wdata1), .l2_mem_rdata(l2_rdata), .l2_mem_resp(l2_resp1)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; l2_resp = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_l2rd", o_l2_rd, 1'b0);
        chk("rst_l2wr", o_l2_wr, 1'b0);
        chk("rst_addr", o_l2_addr, '0);
        chk("rst_wdata", o_l2_wdata, '0);
    endtask

    // Waits for an L2 request, responds after lat cycles; who = {d_resp, i_resp}.
    task automatic run_txn(input int lat, input logic [LW-1:0] rdata,
                           output int who, output logic [AW-1:0] addr);
        bit seen = 1'b0;
        who = 0;
        addr = '0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = o_l2_rd | o_l2_wr;
        end
        if (!seen) begin
            chk("txn_timeout", 1'b0, 1'b1);
            return;
        end
        addr = o_l2_addr;
        repeat (lat) @(negedge clk);
        l2_resp = 1'b1;
        l2_rdata = rdata;
        #1;
        who = {30'd0, o_d_resp, o_i_resp};
        @(negedge clk);
        l2_resp = 1'b0;
    endtask

    task automatic rand_run(input bit prio, input int ncyc);
        int owner = 0;
        bit last_d = 1'b0;
        int lat = 0;
        bit ip = 1'b0, dp = 1'b0, ir, dr;
        int win, r;
        logic t_rd = 1'b0, t_wr = 1'b0;
        logic [AW-1:0] t_addr = '0;
        logic [LW-1:0] t_wd = '0;
        sel = prio;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (!ip) i_rd = 1'b0;
            if (!dp) begin d_rd = 1'b0; d_wr = 1'b0; end
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1; i_rd = 1'b1; i_addr = AW'($urandom);
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 7);
                dp = 1'b1; d_rd = (r < 4) || (r == 7); d_wr = (r >= 4);
                d_addr = AW'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (owner == 2) begin
                d_addr = AW'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (owner == 1) begin
                i_addr = AW'($urandom);
                if ($urandom_range(0, 7) == 0) i_rd = 1'b0;
            end
            if (owner != 0) begin
                l2_resp = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                l2_resp = ($urandom_range(0, 5) == 0);
            end
            l2_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("r_iresp", o_i_resp, (owner == 1) && l2_resp);
            chk("r_dresp", o_d_resp, (owner == 2) && l2_resp);
            if (owner == 1 && l2_resp) chk("r_irdata", o_i_rdata, l2_rdata);
            if (owner == 2 && l2_resp) chk("r_drdata", o_d_rdata, l2_rdata);
            chk("r_l2rd", o_l2_rd, (owner != 0) && t_rd);
            chk("r_l2wr", o_l2_wr, (owner != 0) && t_wr);
            if (owner != 0) begin
                chk("r_addr", o_l2_addr, t_addr);
                chk("r_wdata", o_l2_wdata, t_wd);
            end
            if (owner != 0) begin
                if (l2_resp) begin
                    if (owner == 1) ip = 1'b0; else dp = 1'b0;
                    owner = 0;
                end
            end else begin
                ir = i_rd;
                dr = d_rd | d_wr;
                win = 0;
                if (ir && dr) win = (prio || !last_d) ? 2 : 1;
                else if (ir) win = 1;
                else if (dr) win = 2;
                if (win == 1) begin t_rd = 1'b1; t_wr = 1'b0; t_addr = i_addr; t_wd = '0; end
                if (win == 2) begin t_wr = d_wr; t_rd = !d_wr; t_addr = d_addr; t_wd = d_wdata; end
                if (win != 0) begin owner = win; last_d = (win == 2); lat = $urandom_range(0, 4); end
            end
        end
        @(negedge clk);
        i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0; l2_resp = 1'b0;
    endtask

    initial begin
        int who;
        logic [AW-1:0] a;

        // I-only read, L2 answers three cycles after the request reaches it
        sel = 1'b0;
        do_reset();
        @(negedge clk); i_rd = 1'b1; i_addr = 16'h1230; #1;
        chk("t1_pre_rd", o_l2_rd, 1'b0);
        @(negedge clk); #1;
        chk("t1_rd", o_l2_rd, 1'b1);
        chk("t1_wr", o_l2_wr, 1'b0);
        chk("t1_addr", o_l2_addr, 16'h1230);
        repeat (2) begin @(negedge clk); #1; chk("t1_iresp_early", o_i_resp, 1'b0); end
        @(negedge clk); l2_resp = 1'b1; l2_rdata = {8{16'hAAAA}}; #1;
        chk("t1_iresp", o_i_resp, 1'b1);
        chk("t1_irdata", o_i_rdata, {8{16'hAAAA}});
        chk("t1_dresp", o_d_resp, 1'b0);
        @(negedge clk); l2_resp = 1'b0; i_rd = 1'b0; #1;
        chk("t1_iresp_once", o_i_resp, 1'b0);
        chk("t1_drop", o_l2_rd, 1'b0);

        // D writeback with the live address changing mid-service
        @(negedge clk); d_wr = 1'b1; d_addr = 16'h4000; d_wdata = {16{8'h55}};
        @(negedge clk); #1;
        chk("t2_wr", o_l2_wr, 1'b1);
        chk("t2_rd", o_l2_rd, 1'b0);
        chk("t2_addr", o_l2_addr, 16'h4000);
        d_addr = 16'h4010; d_wdata = '1;
        @(negedge clk); #1;
        chk("t2_addr_hold", o_l2_addr, 16'h4000);
        chk("t2_wdata_hold", o_l2_wdata, {16{8'h55}});
        l2_resp = 1'b1; #1;
        chk("t2_dresp", o_d_resp, 1'b1);
        chk("t2_iresp", o_i_resp, 1'b0);
        @(negedge clk); l2_resp = 1'b0; d_wr = 1'b0; #1;
        chk("t2_dresp_once", o_d_resp, 1'b0);
        chk("t2_drop", o_l2_wr, 1'b0);

        // Spurious L2 response while idle
        @(negedge clk); l2_resp = 1'b1; #1;
        chk("t5_iresp", o_i_resp, 1'b0);
        chk("t5_dresp", o_d_resp, 1'b0);
        @(negedge clk); l2_resp = 1'b0; i_rd = 1'b1; i_addr = 16'h0770; #1;
        chk("t5_idle", o_l2_rd, 1'b0);
        @(negedge clk); #1;
        chk("t5_grant", o_l2_rd, 1'b1);
        chk("t5_addr", o_l2_addr, 16'h0770);
        l2_resp = 1'b1; #1;
        chk("t5_iresp2", o_i_resp, 1'b1);
        @(negedge clk); l2_resp = 1'b0; i_rd = 1'b0;

        // Round-robin: simultaneous requests alternate starting with D
        do_reset();
        @(negedge clk); i_rd = 1'b1; i_addr = 16'h1000; d_rd = 1'b1; d_addr = 16'h2000;
        for (int n = 0; n < 4; n++) begin
            run_txn(n, {4{$urandom}}, who, a);
            chk("t3_order", who, (n % 2 == 0) ? 2 : 1);
            chk("t3_addr", a, (n % 2 == 0) ? 16'h2000 : 16'h1000);
        end
        i_rd = 1'b0; d_rd = 1'b0;

        // Fixed D priority: D keeps winning while it requests
        sel = 1'b1;
        do_reset();
        @(negedge clk); i_rd = 1'b1; i_addr = 16'h1000; d_rd = 1'b1; d_addr = 16'h2000;
        for (int n = 0; n < 3; n++) begin
            run_txn(1, {4{$urandom}}, who, a);
            chk("t4_dwin", who, 2);
        end
        d_rd = 1'b0;
        run_txn(0, {4{$urandom}}, who, a);
        chk("t4_iafter", who, 1);
        i_rd = 1'b0;

        // Reset two cycles into a D service
        sel = 1'b0;
        do_reset();
        @(negedge clk); d_rd = 1'b1; d_addr = 16'h3000;
        @(negedge clk); #1;
        chk("t6_serving", o_l2_rd, 1'b1);
        @(negedge clk); #2;
        reset = 1'b1; #1;
        chk("t6_async_rd", o_l2_rd, 1'b0);
        chk("t6_async_addr", o_l2_addr, '0);
        @(negedge clk); reset = 1'b0; d_rd = 1'b0;
        @(negedge clk); l2_resp = 1'b1; #1;
        chk("t6_late_dresp", o_d_resp, 1'b0);
        @(negedge clk); l2_resp = 1'b0; i_rd = 1'b1; i_addr = 16'h5550;
        run_txn(2, {4{$urandom}}, who, a);
        chk("t6_next_i", who, 1);
        chk("t6_next_addr", a, 16'h5550);
        i_rd = 1'b0;

        rand_run(1'b0, 2000);
        rand_run(1'b1, 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
